ysyx_210544_memu: RTL and testbench

Memory-access stage directly downstream of the execute unit. It takes the execute result plus the load/store operands, runs a single-outstanding request/acknowledge transaction on the core data bus for loads and stores, and then presents a write-back result to the commit stage with a valid/ready handshake. Non-memory instructions pass through with one cycle of latency.

---
 rtl/ysyx_210544_memu_pkg.sv | 60 ++++++
 rtl/ysyx_210544_memu_if.sv | 51 +++++
 rtl/ysyx_210544_memu_lane.sv | 58 +++++
 rtl/ysyx_210544_memu.sv | 136 +++++++++++++
 tb/tb_ysyx_210544_memu.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_210544_memu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_210544_memu_pkg
// Purpose  : Shared defines for the memory-access stage: bus widths, the
//            internal INST_* opcode encoding, FSM state encodings and small
//            opcode classification helpers.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_210544_memu_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [63:0] ZERO_WORD = 64'h0;

    // Internal opcode encoding shared by all pipeline stages
    localparam logic [7:0] INST_NOP = 8'h00;
    localparam logic [7:0] INST_ADD = 8'h01;
    localparam logic [7:0] INST_SUB = 8'h02;
    localparam logic [7:0] INST_LB  = 8'h10;
    localparam logic [7:0] INST_LH  = 8'h11;
    localparam logic [7:0] INST_LW  = 8'h12;
    localparam logic [7:0] INST_LD  = 8'h13;
    localparam logic [7:0] INST_LBU = 8'h14;
    localparam logic [7:0] INST_LHU = 8'h15;
    localparam logic [7:0] INST_LWU = 8'h16;
    localparam logic [7:0] INST_SB  = 8'h18;
    localparam logic [7:0] INST_SH  = 8'h19;
    localparam logic [7:0] INST_SW  = 8'h1A;
    localparam logic [7:0] INST_SD  = 8'h1B;

    // Memory-stage FSM encodings
    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_REQ  = 2'd1;
    localparam logic [1:0] STATE_RESP = 2'd2;

    // True for any load or store opcode
    function automatic logic is_mem(input logic [7:0] op);
        case (op)
            INST_LB, INST_LH, INST_LW, INST_LD,
            INST_LBU, INST_LHU, INST_LWU,
            INST_SB, INST_SH, INST_SW, INST_SD: is_mem = 1'b1;
            default:                             is_mem = 1'b0;
        endcase
    endfunction

    // Natural-alignment check on the byte offset within the 8-byte lane;
    // byte accesses can never be misaligned
    function automatic logic is_misaligned(input logic [7:0] op, input logic [2:0] off);
        case (op)
            INST_LH, INST_LHU, INST_SH: is_misaligned = off[0];
            INST_LW, INST_LWU, INST_SW: is_misaligned = |off[1:0];
            INST_LD, INST_SD:           is_misaligned = |off;
            default:                    is_misaligned = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_210544_memu_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_210544_memu_if
// Purpose  : Bundles the upstream instruction handshake, the commit-side
//            result handshake and the core data bus of the memory stage.
//            Signal names carry the memory stage's own direction (i_ = into
//            the stage, o_ = out of the stage).
//   slave  : view used by the memory stage
//   master : view used by the surrounding pipeline / bus environment
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_210544_memu_if;
    import ysyx_210544_memu_pkg::*;

    // upstream (execute) side
    logic              i_valid;
    logic              o_ready;
    logic [7:0]        i_inst_opcode;
    logic [DATA_W-1:0] i_rd_wdata;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;
    // downstream (commit) side
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_rd_wdata;
    logic              o_mem_err;
    // data bus
    logic              o_dbus_req;
    logic              o_dbus_we;
    logic [ADDR_W-1:0] o_dbus_addr;
    logic [DATA_W-1:0] o_dbus_wdata;
    logic [STRB_W-1:0] o_dbus_wstrb;
    logic              i_dbus_ack;
    logic [DATA_W-1:0] i_dbus_rdata;

    modport slave (
        input  i_valid, i_inst_opcode, i_rd_wdata, i_addr, i_wdata,
        input  i_ready, i_dbus_ack, i_dbus_rdata,
        output o_ready, o_valid, o_rd_wdata, o_mem_err,
        output o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_wdata, o_dbus_wstrb
    );

    modport master (
        output i_valid, i_inst_opcode, i_rd_wdata, i_addr, i_wdata,
        output i_ready, i_dbus_ack, i_dbus_rdata,
        input  o_ready, o_valid, o_rd_wdata, o_mem_err,
        input  o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_wdata, o_dbus_wstrb
    );

endinterface
`default_nettype wire

// File: rtl/ysyx_210544_memu_lane.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_210544_memu_lane
// Purpose  : Purely combinational 8-byte lane steering for the memory stage.
//   i_opcode : latched INST_* opcode
//   i_off    : byte offset within the lane (addr[2:0])
//   i_wdata  : raw store data (rs2)
//   i_rdata  : raw bus read data
//   o_we     : opcode is a store
//   o_wdata  : store data shifted into its byte lanes
//   o_wstrb  : byte strobes for the store
//   o_rdata  : load result, shifted down and sign/zero extended
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_210544_memu_lane
    import ysyx_210544_memu_pkg::*;
(
    input  wire logic [7:0]        i_opcode,
    input  wire logic [2:0]        i_off,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic [DATA_W-1:0] i_rdata,
    output logic                   o_we,
    output logic [DATA_W-1:0]      o_wdata,
    output logic [STRB_W-1:0]      o_wstrb,
    output logic [DATA_W-1:0]      o_rdata
);

    logic [5:0]        w_bit_shift;
    logic [DATA_W-1:0] w_wdata_sh;
    logic [DATA_W-1:0] w_rdata_sh;

    assign w_bit_shift = {i_off, 3'b000};
    assign w_wdata_sh  = i_wdata << w_bit_shift;
    assign w_rdata_sh  = i_rdata >> w_bit_shift;

    always_comb begin
        o_we    = 1'b0;
        o_wdata = ZERO_WORD;
        o_wstrb = '0;
        o_rdata = ZERO_WORD;
        case (i_opcode)
            INST_SB: begin o_we = 1'b1; o_wdata = w_wdata_sh; o_wstrb = 8'h01 << i_off; end
            INST_SH: begin o_we = 1'b1; o_wdata = w_wdata_sh; o_wstrb = 8'h03 << i_off; end
            INST_SW: begin o_we = 1'b1; o_wdata = w_wdata_sh; o_wstrb = 8'h0F << i_off; end
            INST_SD: begin o_we = 1'b1; o_wdata = w_wdata_sh; o_wstrb = 8'hFF;          end
            INST_LB:  o_rdata = {{56{w_rdata_sh[7]}},  w_rdata_sh[7:0]};
            INST_LH:  o_rdata = {{48{w_rdata_sh[15]}}, w_rdata_sh[15:0]};
            INST_LW:  o_rdata = {{32{w_rdata_sh[31]}}, w_rdata_sh[31:0]};
            INST_LD:  o_rdata = w_rdata_sh;
            INST_LBU: o_rdata = {56'h0, w_rdata_sh[7:0]};
            INST_LHU: o_rdata = {48'h0, w_rdata_sh[15:0]};
            INST_LWU: o_rdata = {32'h0, w_rdata_sh[31:0]};
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_210544_memu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_210544_memu
// Purpose  : Memory-access stage. Accepts one instruction at a time from the
//            execute stage, runs a single-outstanding req/ack transaction on
//            the data bus for aligned loads/stores, and hands the write-back
//            result to commit with a valid/ready handshake. Non-memory ops
//            and misaligned accesses go straight to the result state.
//   clk  : core clock
//   rst  : synchronous active-high reset
//   bus  : upstream handshake, commit handshake and data bus (slave view)
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_210544_memu
    import ysyx_210544_memu_pkg::*;
(
    input  wire logic           clk,
    input  wire logic           rst,
    ysyx_210544_memu_if.slave   bus
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              w_accept;
    logic              w_acc_mem;
    logic              w_acc_misaligned;

    logic [7:0]        r_opcode;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rd_wdata;
    logic              r_mem_err;

    logic              w_we;
    logic [DATA_W-1:0] w_st_wdata;
    logic [STRB_W-1:0] w_st_wstrb;
    logic [DATA_W-1:0] w_ld_data;

    assign w_accept         = bus.i_valid && (r_state == STATE_IDLE);
    assign w_acc_mem        = is_mem(bus.i_inst_opcode);
    assign w_acc_misaligned = is_misaligned(bus.i_inst_opcode, bus.i_addr[2:0]);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= STATE_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            STATE_IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_acc_mem && !w_acc_misaligned) ? STATE_REQ : STATE_RESP;
                end
            end
            STATE_REQ: begin
                if (bus.i_dbus_ack) begin
                    w_state_next = STATE_RESP;
                end
            end
            STATE_RESP: begin
                if (bus.i_ready) begin
                    w_state_next = STATE_IDLE;
                end
            end
            default: w_state_next = STATE_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.o_ready    = (r_state == STATE_IDLE);
        bus.o_dbus_req = (r_state == STATE_REQ);
        bus.o_valid    = (r_state == STATE_RESP);
    end

    // ------------------------------------------------------------------
    // Datapath: the instruction is latched at accept, so every bus field
    // derived from it is stable for the whole REQ phase without extra
    // output registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opcode   <= INST_NOP;
            r_addr     <= '0;
            r_wdata    <= ZERO_WORD;
            r_rd_wdata <= ZERO_WORD;
            r_mem_err  <= 1'b0;
        end else if (w_accept) begin
            r_opcode <= bus.i_inst_opcode;
            r_addr   <= bus.i_addr;
            r_wdata  <= bus.i_wdata;
            if (!w_acc_mem) begin
                r_rd_wdata <= bus.i_rd_wdata;
                r_mem_err  <= 1'b0;
            end else begin
                // stores keep zero; loads overwrite at the ack edge
                r_rd_wdata <= ZERO_WORD;
                r_mem_err  <= w_acc_misaligned;
            end
        end else if ((r_state == STATE_REQ) && bus.i_dbus_ack && !w_we) begin
            r_rd_wdata <= w_ld_data;
        end
    end

    ysyx_210544_memu_lane u_lane (
        .i_opcode (r_opcode),
        .i_off    (r_addr[2:0]),
        .i_wdata  (r_wdata),
        .i_rdata  (bus.i_dbus_rdata),
        .o_we     (w_we),
        .o_wdata  (w_st_wdata),
        .o_wstrb  (w_st_wstrb),
        .o_rdata  (w_ld_data)
    );

    assign bus.o_dbus_we    = w_we;
    assign bus.o_dbus_addr  = {r_addr[ADDR_W-1:3], 3'b000};
    assign bus.o_dbus_wdata = w_st_wdata;
    assign bus.o_dbus_wstrb = w_st_wstrb;
    assign bus.o_rd_wdata   = r_rd_wdata;
    assign bus.o_mem_err    = r_mem_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_210544_memu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_210544_memu
// Purpose  : Directed self-checking bench for the memory-access stage.
//            Inputs change and outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_210544_memu;
    import ysyx_210544_memu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_210544_memu_if bus();

    ysyx_210544_memu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Present one instruction for exactly one rising edge
    task automatic issue(input logic [7:0] op, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rdw);
        bus.i_valid       = 1'b1;
        bus.i_inst_opcode = op;
        bus.i_addr        = addr;
        bus.i_wdata       = wdata;
        bus.i_rd_wdata    = rdw;
        @(negedge clk);
        bus.i_valid       = 1'b0;
    endtask

    task automatic test_reset();
        bus.i_valid = 1'b0; bus.i_inst_opcode = INST_NOP; bus.i_addr = '0;
        bus.i_wdata = '0; bus.i_rd_wdata = '0; bus.i_ready = 1'b1;
        bus.i_dbus_ack = 1'b0; bus.i_dbus_rdata = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus.o_ready); end
        n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.o_valid); end
        n_checks++; if (bus.o_dbus_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", bus.o_dbus_req); end
        n_checks++; if (bus.o_dbus_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", bus.o_dbus_we); end
        n_checks++; if (bus.o_mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.o_mem_err); end
        n_checks++; if (bus.o_rd_wdata !== 64'h0) begin n_fail++; $display("FAIL reset_rd got %h want 0", bus.o_rd_wdata); end
        n_checks++; if (bus.o_dbus_addr !== 64'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", bus.o_dbus_addr); end
        n_checks++; if (bus.o_dbus_wstrb !== 8'h0) begin n_fail++; $display("FAIL reset_wstrb got %h want 0", bus.o_dbus_wstrb); end
        n_checks++; if (bus.o_dbus_wdata !== 64'h0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", bus.o_dbus_wdata); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_passthrough();
        bus.i_ready = 1'b1;
        issue(INST_ADD, 64'h8000_0000, 64'h0, 64'h1234);
        n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL pass_valid got %b want 1", bus.o_valid); end
        n_checks++; if (bus.o_rd_wdata !== 64'h1234) begin n_fail++; $display("FAIL pass_rd got %h want 1234", bus.o_rd_wdata); end
        n_checks++; if (bus.o_dbus_req !== 1'b0) begin n_fail++; $display("FAIL pass_req got %b want 0", bus.o_dbus_req); end
        n_checks++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL pass_busy got %b want 0", bus.o_ready); end
        @(negedge clk);
        n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL pass_vdrop got %b want 0", bus.o_valid); end
        n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL pass_ready got %b want 1", bus.o_ready); end
        n_checks++; if (bus.o_dbus_req !== 1'b0) begin n_fail++; $display("FAIL pass_req2 got %b want 0", bus.o_dbus_req); end
    endtask

    // One aligned load or store with a given number of wait cycles before ack
    task automatic run_mem(input string name, input logic [7:0] op, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] rdata, input int waits,
                           input logic exp_we, input logic [7:0] exp_strb,
                           input logic [63:0] exp_dwdata, input logic [63:0] exp_rd);
        logic [63:0] exp_addr;
        exp_addr = {addr[63:3], 3'b000};
        bus.i_ready = 1'b1;
        issue(op, addr, wdata, 64'hDEAD_0000_DEAD_0000);
        for (int k = 0; k <= waits; k++) begin
            n_checks++; if (bus.o_dbus_req !== 1'b1) begin n_fail++; $display("FAIL %s_req[%0d] got %b want 1", name, k, bus.o_dbus_req); end
            n_checks++; if (bus.o_dbus_addr !== exp_addr) begin n_fail++; $display("FAIL %s_addr[%0d] got %h want %h", name, k, bus.o_dbus_addr, exp_addr); end
            n_checks++; if (bus.o_dbus_we !== exp_we) begin n_fail++; $display("FAIL %s_we[%0d] got %b want %b", name, k, bus.o_dbus_we, exp_we); end
            n_checks++; if (bus.o_dbus_wstrb !== exp_strb) begin n_fail++; $display("FAIL %s_wstrb[%0d] got %h want %h", name, k, bus.o_dbus_wstrb, exp_strb); end
            n_checks++; if (bus.o_dbus_wdata !== exp_dwdata) begin n_fail++; $display("FAIL %s_wdata[%0d] got %h want %h", name, k, bus.o_dbus_wdata, exp_dwdata); end
            n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL %s_early_valid[%0d] got %b want 0", name, k, bus.o_valid); end
            if (k == waits) begin
                bus.i_dbus_ack = 1'b1;
                bus.i_dbus_rdata = rdata;
            end
            @(negedge clk);
        end
        bus.i_dbus_ack = 1'b0;
        bus.i_dbus_rdata = 64'h5555_5555_5555_5555;
        n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid got %b want 1", name, bus.o_valid); end
        n_checks++; if (bus.o_dbus_req !== 1'b0) begin n_fail++; $display("FAIL %s_reqdrop got %b want 0", name, bus.o_dbus_req); end
        n_checks++; if (bus.o_rd_wdata !== exp_rd) begin n_fail++; $display("FAIL %s_rd got %h want %h", name, bus.o_rd_wdata, exp_rd); end
        n_checks++; if (bus.o_mem_err !== 1'b0) begin n_fail++; $display("FAIL %s_err got %b want 0", name, bus.o_mem_err); end
        @(negedge clk);
        n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready got %b want 1", name, bus.o_ready); end
    endtask

    task automatic test_loads();
        run_mem("lb",  INST_LB,  64'h8000_0005, 64'h0, 64'h0000_8000_0000_0000, 3, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80);
        run_mem("lbu", INST_LBU, 64'h8000_0005, 64'h0, 64'h0000_8000_0000_0000, 3, 1'b0, 8'h00, 64'h0, 64'h0000_0000_0000_0080);
        run_mem("lh",  INST_LH,  64'h8000_0012, 64'h0, 64'h0000_0000_8001_0000, 0, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001);
        run_mem("lhu", INST_LHU, 64'h8000_0012, 64'h0, 64'h0000_0000_8001_0000, 0, 1'b0, 8'h00, 64'h0, 64'h0000_0000_0000_8001);
        run_mem("lw",  INST_LW,  64'h8000_0104, 64'h0, 64'hF000_0000_1111_1111, 1, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_F000_0000);
        run_mem("lwu", INST_LWU, 64'h8000_0104, 64'h0, 64'hF000_0000_1111_1111, 1, 1'b0, 8'h00, 64'h0, 64'h0000_0000_F000_0000);
        run_mem("ld",  INST_LD,  64'h8000_0008, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 1'b0, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF);
    endtask

    task automatic test_stores();
        run_mem("sh", INST_SH, 64'h8000_0006, 64'hABCD, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b1, 8'hC0, 64'hABCD_0000_0000_0000, 64'h0);
        run_mem("sb", INST_SB, 64'h8000_0003, 64'hFF5A, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1, 8'h08, 64'h0000_00FF_5A00_0000, 64'h0);
        run_mem("sw", INST_SW, 64'h8000_0004, 64'h1122_3344, 64'h0, 1, 1'b1, 8'hF0, 64'h1122_3344_0000_0000, 64'h0);
        run_mem("sd", INST_SD, 64'h8000_0000, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 0, 1'b1, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 64'h0);
    endtask

    task automatic test_misaligned();
        logic [7:0]  ops   [4];
        logic [63:0] addrs [4];
        ops[0] = INST_LW;  addrs[0] = 64'h8000_0002;
        ops[1] = INST_LD;  addrs[1] = 64'h8000_0004;
        ops[2] = INST_SH;  addrs[2] = 64'h8000_0001;
        ops[3] = INST_LHU; addrs[3] = 64'h8000_0007;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            // leave a nonzero result behind so the zeroing is observable
            issue(INST_ADD, 64'h0, 64'h0, 64'h7777);
            @(negedge clk);
            issue(ops[i], addrs[i], 64'h1234_5678, 64'h9999);
            n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL mis%0d_valid got %b want 1", i, bus.o_valid); end
            n_checks++; if (bus.o_mem_err !== 1'b1) begin n_fail++; $display("FAIL mis%0d_err got %b want 1", i, bus.o_mem_err); end
            n_checks++; if (bus.o_rd_wdata !== 64'h0) begin n_fail++; $display("FAIL mis%0d_rd got %h want 0", i, bus.o_rd_wdata); end
            n_checks++; if (bus.o_dbus_req !== 1'b0) begin n_fail++; $display("FAIL mis%0d_req got %b want 0", i, bus.o_dbus_req); end
            @(negedge clk);
            n_checks++; if (bus.o_dbus_req !== 1'b0) begin n_fail++; $display("FAIL mis%0d_req2 got %b want 0", i, bus.o_dbus_req); end
            n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL mis%0d_ready got %b want 1", i, bus.o_ready); end
        end
    endtask

    task automatic test_backpressure();
        bus.i_ready = 1'b0;
        issue(INST_LD, 64'h8000_0008, 64'h0, 64'h0);
        bus.i_dbus_ack = 1'b1;
        bus.i_dbus_rdata = 64'hCAFE_BABE_0000_1111;
        @(negedge clk);
        bus.i_dbus_ack = 1'b0;
        bus.i_dbus_rdata = 64'h0;
        // a competing instruction waits at the input the whole time
        bus.i_valid = 1'b1; bus.i_inst_opcode = INST_ADD; bus.i_rd_wdata = 64'h4242;
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", k, bus.o_valid); end
            n_checks++; if (bus.o_rd_wdata !== 64'hCAFE_BABE_0000_1111) begin n_fail++; $display("FAIL bp_rd[%0d] got %h want cafebabe00001111", k, bus.o_rd_wdata); end
            n_checks++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %b want 0", k, bus.o_ready); end
            n_checks++; if (bus.o_mem_err !== 1'b0) begin n_fail++; $display("FAIL bp_err[%0d] got %b want 0", k, bus.o_mem_err); end
            @(negedge clk);
        end
        bus.i_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", bus.o_valid); end
        n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", bus.o_ready); end
        @(negedge clk);
        bus.i_valid = 1'b0;
        n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid got %b want 1", bus.o_valid); end
        n_checks++; if (bus.o_rd_wdata !== 64'h4242) begin n_fail++; $display("FAIL bp_next_rd got %h want 4242", bus.o_rd_wdata); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_request();
        bus.i_ready = 1'b1;
        issue(INST_LD, 64'h8000_0010, 64'h0, 64'h0);
        n_checks++; if (bus.o_dbus_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req_before got %b want 1", bus.o_dbus_req); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (bus.o_dbus_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req got %b want 0", bus.o_dbus_req); end
        n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b want 0", bus.o_valid); end
        n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %b want 1", bus.o_ready); end
        bus.i_dbus_ack = 1'b1;
        bus.i_dbus_rdata = 64'h1111_2222_3333_4444;
        @(negedge clk);
        bus.i_dbus_ack = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_late_valid got %b want 0", bus.o_valid); end
        n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_late_ready got %b want 1", bus.o_ready); end
        n_checks++; if (bus.o_rd_wdata !== 64'h0) begin n_fail++; $display("FAIL rmid_late_rd got %h want 0", bus.o_rd_wdata); end
        n_checks++; if (bus.o_dbus_req !== 1'b0) begin n_fail++; $display("FAIL rmid_late_req got %b want 0", bus.o_dbus_req); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_loads();
        test_stores();
        test_misaligned();
        test_backpressure();
        test_reset_mid_request();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
